// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount sequencer: slice width, FSM state
// encoding and the count-width helper.
package popcount_pkg;

    localparam int SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Bits needed to represent any value 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount_sequencer_ones_count7.sv
// ones_count7: combinational 7-input ones counter built from 3:2 counters.
// Two full adders reduce the first six bits, a third folds in bit 6 to give
// the weight-1 result, and a fourth sums the three weight-2 carries.
module ones_count7 (
    input  logic [6:0] bits_i,
    output logic [2:0] cnt_o
);

    logic s1_s, c1_s, s2_s, c2_s, s3_s, c3_s, s4_s, c4_s;

    assign s1_s = bits_i[0] ^ bits_i[1] ^ bits_i[2];
    assign c1_s = (bits_i[0] & bits_i[1]) | (bits_i[0] & bits_i[2]) | (bits_i[1] & bits_i[2]);

    assign s2_s = bits_i[3] ^ bits_i[4] ^ bits_i[5];
    assign c2_s = (bits_i[3] & bits_i[4]) | (bits_i[3] & bits_i[5]) | (bits_i[4] & bits_i[5]);

    assign s3_s = s1_s ^ s2_s ^ bits_i[6];
    assign c3_s = (s1_s & s2_s) | (s1_s & bits_i[6]) | (s2_s & bits_i[6]);

    assign s4_s = c1_s ^ c2_s ^ c3_s;
    assign c4_s = (c1_s & c2_s) | (c1_s & c3_s) | (c2_s & c3_s);

    assign cnt_o = {c4_s, s4_s, s3_s};

endmodule

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts the ones in a 7*N_SLICES-bit word by streaming
// one 7-bit slice per clock through a single shared ones counter.
// Optional feature macro: POPCOUNT_EARLY_EXIT_EN -- finish as soon as the
// remaining shifted-out bits are all zero.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int N_SLICES = 4,
    localparam int W        = SLICE_W * N_SLICES,
    localparam int CW       = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          busy
);

    localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

    pc_state_t     state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;

    logic [2:0]    slice_cnt_s;
    logic [CW-1:0] acc_sum_s;
    logic          last_slice_s;

    ones_count7 u_ones (
        .bits_i (sr_q[SLICE_W-1:0]),
        .cnt_o  (slice_cnt_s)
    );

    assign acc_sum_s = acc_q + CW'(slice_cnt_s);

`ifdef POPCOUNT_EARLY_EXIT_EN
    assign last_slice_s = (idx_q == IW'(N_SLICES - 1)) || ((sr_q >> SLICE_W) == {W{1'b0}});
`else
    assign last_slice_s = (idx_q == IW'(N_SLICES - 1));
`endif

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign count     = count_q;

    // Next-state and datapath update for the accept / shift-accumulate / hold sequence.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = data_in;
                    acc_d   = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_sum_s;
                sr_d  = sr_q >> SLICE_W;
                idx_d = idx_q + IW'(1);
                if (last_slice_s) begin
                    count_d = acc_sum_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an in-flight word is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= {W{1'b0}};
            acc_q   <= {CW{1'b0}};
            idx_q   <= {IW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed bench for popcount_sequencer: a 4-slice instance for the main
// scenarios and a 1-slice instance for back-to-back random words.
module tb_popcount_sequencer;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_cmp;
    int          n_err;

    // 4-slice instance
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [27:0] data_in;
    logic [4:0]  count;

    // 1-slice instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [6:0]  data1;
    logic [2:0]  count1;

    popcount_sequencer #(.N_SLICES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .busy(busy)
    );

    popcount_sequencer #(.N_SLICES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .count(count1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure the word period.
    always @(posedge clk) cyc <= cyc + 1;

`ifdef POPCOUNT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || count1 !== 3'd0) begin
            n_err++; $display("FAIL reset_n1 got rdy=%b vld=%b busy=%b cnt=%0d exp 1 0 0 0", in_ready1, out_valid1, busy1, count1);
        end
    endtask

    // Send one word to the 4-slice instance with out_ready high and check result/timing.
    task automatic run_word(input logic [27:0] d, input int exp_cnt, input int exp_lat, input string nm);
        int lat, busy_n;
        bit got;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
        data_in  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid === 1'b1) got = 1'b1;
            else if (busy === 1'b1) busy_n++;
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL %s_timeout got=no out_valid exp=out_valid", nm); end
        n_cmp++; if (lat != exp_lat) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); end
        n_cmp++; if (busy_n != exp_lat) begin n_err++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, busy_n, exp_lat); end
        n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL %s_count got=%0d exp=%0d", nm, count, exp_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_handshake got vld=%b rdy=%b exp 0 1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_count();
        run_word(28'hFFFFFFF, 28, 4, "all_ones");
        run_word(28'h0000001, 1, EE ? 1 : 4, "lsb_only");
        run_word(28'h8000000, 1, 4, "msb_only");
        run_word(28'h0000000, 0, EE ? 1 : 4, "zero");
        run_word(28'h5A5A5A5, 14, 4, "pattern");
    endtask

    task automatic test_backpressure();
        bit got;
        out_ready = 1'b0;
        @(negedge clk);
        data_in  = 28'h0F0F0F0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 28'h0000003;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
        n_cmp++; if (count !== 5'd12) begin n_err++; $display("FAIL bp_count got=%0d exp=12", count); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (count !== 5'd12 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold cyc%0d got cnt=%0d rdy=%b vld=%b exp 12 0 1", i, count, in_ready, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_next_accept got busy=%b rdy=%b exp 1 0", busy, in_ready);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got || count !== 5'd2) begin
            n_err++; $display("FAIL bp_next_count got vld=%b cnt=%0d exp 1 2", got, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        data_in  = 28'hFFFFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || count !== 5'd0) begin
            n_err++; $display("FAIL rst_mid_run got rdy=%b busy=%b vld=%b cnt=%0d exp 1 0 0 0", in_ready, busy, out_valid, count);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL rst_no_valid got=out_valid pulse exp=none"); end
        run_word(28'h1234567, 12, 4, "after_rst");
    endtask

    task automatic test_back_to_back();
        bit rdy, got;
        int prev, acc_cyc;
        logic [6:0] d;
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        prev = 0;
        for (int w = 0; w < 200; w++) begin
            rdy = 1'b0;
            for (int t = 0; t < 10 && !rdy; t++) begin
                @(negedge clk);
                if (in_ready1 === 1'b1) rdy = 1'b1;
            end
            n_cmp++; if (!rdy) begin n_err++; $display("FAIL b2b_ready w%0d got=0 exp=1", w); end
            d = 7'($urandom_range(0, 127));
            data1 = d;
            @(posedge clk); #1;
            acc_cyc = cyc;
            if (w > 0) begin
                n_cmp++; if (acc_cyc - prev != 3) begin
                    n_err++; $display("FAIL b2b_period w%0d got=%0d exp=3", w, acc_cyc - prev);
                end
            end
            prev = acc_cyc;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(posedge clk); #1;
                if (out_valid1 === 1'b1) got = 1'b1;
            end
            n_cmp++; if (!got || count1 !== 3'($countones(d))) begin
                n_err++; $display("FAIL b2b_count w%0d data=%h got vld=%b cnt=%0d exp 1 %0d", w, d, got, count1, $countones(d));
            end
        end
        in_valid1 = 1'b0;
    endtask

    initial begin
        clk = 1'b0; cyc = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; data_in = 28'h0; out_ready = 1'b1;
        in_valid1 = 1'b0; data1 = 7'h0; out_ready1 = 1'b1;
        #23;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_count();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_sequencer.md
# popcount_sequencer

Multi-cycle population counter for wide words. It shares a single 7-bit ones-counter slice across a `7*N_SLICES`-bit input, streaming one 7-bit slice per clock. It accumulates the per-slice counts and returns the total through a valid/ready output. It sits between a word producer and a count consumer wherever a full-width combinational popcount is too large.

## Interface
- `N_SLICES`, default 4: number of 7-bit slices. Word width `W = 7*N_SLICES`; legal range is 1 to 64.
- `CW`, derived as `$clog2(W+1)`, default 5: count width. It is a localparam and not overridable.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high. One clock domain; reset polarity and synchronicity are fixed.
- `in_valid`  in  1  producer offers `data_in`.
- `in_ready`  out  1  block can accept a word. High only in IDLE.
- `data_in`  in  W  word to count. Sampled only on the accept edge.
- `out_valid`  out  1  `count` is valid. High only in DONE.
- `out_ready`  in  1  consumer takes `count`.
- `count`  out  CW  number of ones in the accepted word. Registered.
- `busy`  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: load `data_in` into shift register `sr`, clear accumulator `acc`, clear slice index `idx`, go to RUN.
- **RUN**, one slice per cycle:
  - `s = sr[6:0]` feeds the ones-counter; its 3-bit result `c` (0–7) is zero-extended and added, `acc <= acc + c`.
  - `sr <= sr >> 7` and `idx <= idx + 1`.
  - Last slice condition: `idx == N_SLICES-1`. When it holds, go to DONE with the final sum latched into `count`.
- **DONE**
  - `out_valid`=1 and `count` is held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored; `in_ready`=0.
- Arithmetic: `acc` is CW bits wide and cannot overflow, since its maximum is W.
- `count` holds its last value in IDLE and RUN and is updated only on entry to DONE.
- An `in_valid` held high during RUN or DONE is not consumed.
- Reset values, asynchronous and applied immediately on `rst`:
  - state=IDLE;
  - `acc`, `sr`, `idx`, `count` = 0;
  - `out_valid`=0, `busy`=0, `in_ready`=1.
- Reset mid-RUN or in DONE discards the word; no `out_valid` pulse follows.

## Timing
- Accept edge is edge k.
- RUN covers edges k+1 .. k+N_SLICES.
- `out_valid` is high from just after edge k+N_SLICES, so latency is N_SLICES cycles.
- With `out_ready` already high, the output handshake completes on edge k+N_SLICES+1. IDLE can accept again on edge k+N_SLICES+2, so the minimum period is N_SLICES+2 cycles per word.
- Output backpressure: DONE persists indefinitely; `count` and `out_valid` stay stable.
- `in_ready`, `out_valid` and `busy` are decoded from state registers only, with no combinational path from inputs.

## Configuration
- Macro: `POPCOUNT_EARLY_EXIT_EN`.
- Defined: in RUN, the last slice condition becomes `idx == N_SLICES-1 || (sr >> 7) == 0`. Latency is then (index of highest nonzero slice)+1, with a minimum of 1. An all-zero word finishes in 1 RUN cycle.
- Undefined: latency is always exactly N_SLICES. This is the default build.
- The `count` value is identical in both builds.

## Structure
- Package `popcount_pkg`:
  - `SLICE_W=7`;
  - state enum `pc_state_t` {IDLE, RUN, DONE};
  - function `cnt_width(w)` returning `$clog2(w+1)`.
- Sub-module `ones_count7`: combinational 7-input ones counter, 3-bit output. It is a tree of 3-input full-adder counters. Exactly one instance, driven by `sr[6:0]`.
- Top level holds the FSM, `sr`, `acc`, `idx` and output registers.

## Test plan
- N=4, `data_in`=28'hFFFFFFF, `out_ready`=1: `count`=28, `out_valid` rises 4 cycles after the accept edge, `busy` high for 4 cycles.
- N=4, `data_in`=28'h0000001: `count`=1. With `POPCOUNT_EARLY_EXIT_EN`, latency is 1. Without it, latency is 4.
- N=4, `data_in`=28'h8000000 under `POPCOUNT_EARLY_EXIT_EN`: `count`=1, latency 4. `data_in`=0: `count`=0, latency 1.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 → `count` stable, `in_ready`=0. Release → the next word is accepted 1 cycle after the output handshake.
- Assert `rst` during the 2nd RUN cycle → outputs take reset values at once, no `out_valid` follows, and a new word after reset counts correctly.
- N_SLICES=1, random 7-bit words over 200 back-to-back transactions → `count` matches a reference popcount, and the period is 3 cycles per word.
